perf_counter_bank: RTL and testbench

Parametrised, multi-channel performance counter bank that supersedes the single free-running 16-bit cycle counter in the multicycle processor top level. Channel 0 counts clock cycles and channels 1..NUM_CH-1 count per-cycle event strobes from the FSM/datapath (e.g. MemRead, RFWrite, PCWrite). A run-control state machine, wrap or saturate overflow handling, and an atomic snapshot register feed the HEX display muxes.

---
 rtl/perf_pkg.sv | 14 +
 rtl/perf_channel.sv | 67 ++++++
 rtl/perf_counter_bank.sv | 95 +++++++++
 tb/tb_perf_counter_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: run-control state
// encoding and the default geometry reused by the HEX display wiring.
package perf_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_HALTED  = 2'd2
  } run_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

endpackage : perf_pkg

// File: rtl/perf_channel.sv
// One performance counter channel: live counter, sticky overflow flag and the
// shadow register that is loaded atomically with its siblings on a snapshot.
module perf_channel
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             inc,
  input  logic             snap,
  output logic             overflow,
  output logic [CNT_W-1:0] shadow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;

  // NOTE: every always_comb output gets its hold value first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A snapshot taken on the clearing edge keeps the pre-clear value.
  always_comb begin
    shadow_d = shadow_q;
    if (snap) begin
      shadow_d = cnt_q;
    end else if (clear) begin
      shadow_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the shadow is reset like any other register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
    end
  end

  assign overflow = ovf_q;
  assign shadow   = shadow_q;

endmodule : perf_channel

// File: rtl/perf_counter_bank.sv
// Multi-channel performance counter bank: channel 0 counts cycles, the rest
// count event strobes, under an IDLE/RUNNING/HALTED run-control FSM.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter  int NUM_CH   = DEF_NUM_CH,
  parameter  int CNT_W    = DEF_CNT_W,
  parameter  int SATURATE = 0,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [NUM_CH-1:0] events,
  input  logic              snap_req,
  output logic              snap_valid,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] overflow,
  output logic              running
);

  run_state_e state_q, state_d;
  logic       snap_valid_q;
  logic       count_en;

  logic [NUM_CH-1:0] inc;
  logic [CNT_W-1:0]  shadow [NUM_CH];

  // Clear outranks everything; start with stop in IDLE only starts.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (start) state_d = S_RUNNING;
        S_RUNNING: if (stop)  state_d = S_HALTED;
        S_HALTED:  state_d = S_HALTED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_valid_q <= snap_req;
    end
  end

  // The first cycle with stop high no longer counts, as the old !Stop gate did.
  assign count_en = (state_q == S_RUNNING) && !stop && !clear;

  // Channel 0 is the cycle counter, so its event strobe is unused.
  logic unused_evt0;
  assign unused_evt0 = events[0];

  always_comb begin
    inc    = events & {NUM_CH{count_en}};
    inc[0] = count_en;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_channel #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE != 0)
    ) u_ch (
      .clock    (clock),
      .resetn   (resetn),
      .clear    (clear),
      .inc      (inc[g]),
      .snap     (snap_req),
      .overflow (overflow[g]),
      .shadow   (shadow[g])
    );
  end

  // Select values that name no channel read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data = shadow[i];
    end
  end

  assign snap_valid = snap_valid_q;
  assign running    = (state_q == S_RUNNING);

endmodule : perf_counter_bank

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a default bank (4 x 16 bit) and two 3 x 8 bit banks, one
// wrapping and one saturating, all driven by the same control stimulus.
module tb_perf_counter_bank;

  logic       clock = 1'b0;
  logic       resetn, start, stop, clear, snap_req;
  logic [3:0] events;
  logic [1:0] rd_sel;

  logic        sv_m, sv_w, sv_s, run_m, run_w, run_s;
  logic [15:0] rd_m;
  logic [7:0]  rd_w, rd_s;
  logic [3:0]  ovf_m;
  logic [2:0]  ovf_w, ovf_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(16), .SATURATE(0)) dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .events(events), .snap_req(snap_req), .snap_valid(sv_m), .rd_sel(rd_sel),
    .rd_data(rd_m), .overflow(ovf_m), .running(run_m)
  );

  perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SATURATE(0)) dut_w (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .events(events[2:0]), .snap_req(snap_req), .snap_valid(sv_w), .rd_sel(rd_sel),
    .rd_data(rd_w), .overflow(ovf_w), .running(run_w)
  );

  perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SATURATE(1)) dut_s (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .events(events[2:0]), .snap_req(snap_req), .snap_valid(sv_s), .rd_sel(rd_sel),
    .rd_data(rd_s), .overflow(ovf_s), .running(run_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic snap();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  initial begin
    logic [7:0] ev_pat;
    resetn = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    snap_req = 1'b0; events = '0; rd_sel = '0;
    #2 resetn = 1'b0;
    step(2);
    resetn = 1'b1;

    check("rst_running", 32'(run_m), 0);
    check("rst_overflow", 32'(ovf_m), 0);
    check("rst_snap_valid", 32'(sv_m), 0);
    check("rst_rd_data", 32'(rd_m), 0);

    // 1: ten counted cycles after the start edge
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_running_rises", 32'(run_m), 1);
    step(10);
    snap();
    check("t1_snap_valid", 32'(sv_m), 1);
    check("t1_ch0", 32'(rd_m), 10);
    check("t1_running", 32'(run_m), 1);
    step();
    check("t1_snap_valid_once", 32'(sv_m), 0);

    // 2: five events over eight cycles, then halt; ch0 reaches 20
    ev_pat = 8'b1011_0101;
    for (int i = 0; i < 8; i++) begin
      events[1] = ev_pat[i];
      step();
    end
    stop = 1'b1; events[1] = 1'b1;
    step();
    stop = 1'b0;
    check("t2_halted", 32'(run_m), 0);
    step(3);
    events = '0;
    snap();
    rd_sel = 2'd1; #1;
    check("t2_ch1", 32'(rd_m), 5);
    rd_sel = 2'd0; #1;
    check("t2_ch0_frozen", 32'(rd_m), 20);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2_start_in_halted", 32'(run_m), 0);
    step(4);
    snap();
    check("t2_no_resume", 32'(rd_m), 20);

    // 4: clear and snapshot on the same edge keep the pre-clear shadows
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    events[2] = 1'b1;
    step(7);
    events = '0;
    clear = 1'b1; snap_req = 1'b1;
    step();
    clear = 1'b0; snap_req = 1'b0;
    rd_sel = 2'd2; #1;
    check("t4_shadow2_preclear", 32'(rd_m), 7);
    check("t4_snap_valid", 32'(sv_m), 1);
    check("t4_idle", 32'(run_m), 0);
    snap();
    check("t4_shadow2_cleared", 32'(rd_m), 0);
    check("t4_overflow", 32'(ovf_m), 0);
    check("t4_still_idle", 32'(run_m), 0);

    // 3: 260 counted cycles on the 8-bit banks
    rd_sel = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(260);
    snap();
    check("t3_wrap_rd", 32'(rd_w), 4);
    check("t3_wrap_ovf", 32'(ovf_w), 32'b001);
    check("t3_sat_rd", 32'(rd_s), 255);
    check("t3_sat_ovf", 32'(ovf_s), 32'b001);
    check("t3_wide_rd", 32'(rd_m), 260);
    check("t3_wide_ovf", 32'(ovf_m), 0);

    // 5: asynchronous reset between edges while counting
    #3 resetn = 1'b0;
    #1;
    check("t5_async_running", 32'({run_m, run_w, run_s}), 0);
    check("t5_async_ovf", 32'({ovf_m, ovf_w, ovf_s}), 0);
    check("t5_async_rd", 32'({rd_m, rd_w, rd_s}), 0);
    check("t5_async_snap_valid", 32'({sv_m, sv_w, sv_s}), 0);
    step(2);
    resetn = 1'b1;
    step(5);
    snap();
    check("t5_no_count_idle", 32'(rd_m), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    snap();
    check("t5_recount", 32'(rd_w), 3);

    // 6: select beyond the last channel of a three-channel bank
    rd_sel = 2'd3; #1;
    check("t6_wrap_oob", 32'(rd_w), 0);
    check("t6_sat_oob", 32'(rd_s), 0);

    // start and stop together in IDLE: start only, stop acts next cycle
    clear = 1'b1;
    step();
    clear = 1'b0;
    rd_sel = 2'd0;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0;
    check("ss_running", 32'(run_m), 1);
    step();
    stop = 1'b0;
    check("ss_halted", 32'(run_m), 0);
    snap();
    check("ss_no_count", 32'(rd_m), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_perf_counter_bank
